// File: rtl/ag32gbd_ahb_frame_reader.sv
// AHB-lite responder letting the CPU read capture status, frame count, frame IRQ and BRAM frame bytes.
// Optional DMA single-request output is enabled with `define AHB_DMA_REQ_EN.
module ag32gbd_ahb_frame_reader #(
    parameter int          TIMEOUT_CYCLES = 64,
    parameter logic [11:0] WIN_BASE       = 12'h400
) (
    input  logic        sys_clock,
    input  logic        resetn,
    input  logic [1:0]  mem_ahb_htrans,
    input  logic        mem_ahb_hready,
    input  logic        mem_ahb_hwrite,
    input  logic [31:0] mem_ahb_haddr,
    input  logic [2:0]  mem_ahb_hsize,
    input  logic [31:0] mem_ahb_hwdata,
    output logic        mem_ahb_hreadyout,
    output logic        mem_ahb_hresp,
    output logic [31:0] mem_ahb_hrdata,
    input  logic        cam_capture,
    input  logic        cam_capture_finish,
    output logic        buf_req,
    output logic [9:0]  buf_offset,
    input  logic [7:0]  buf_data,
    input  logic        buf_ready,
    output logic        irq,
    output logic        dma_sreq,
    input  logic        dma_clr
);
    localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;

    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_GAP, S_DONE, S_ERR1, S_ERR2} state_t;

    state_t        state_q, state_d;
    logic          hreadyout_q, hreadyout_d;
    logic          hresp_q, hresp_d;
    logic [31:0]   hrdata_q, hrdata_d;
    logic          buf_req_q, buf_req_d;
    logic [9:0]    buf_off_q, buf_off_d;
    logic [1:0]    k_q, k_d;
    logic [6:0]    idx_q, idx_d;
    logic [23:0]   bytes_q, bytes_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          wr_pend_q, wr_pend_d;
    logic [11:0]   wr_addr_q, wr_addr_d;
    logic          fin_q, fin_d;
    logic          frame_ready_q, frame_ready_d;
    logic          overflow_q, overflow_d;
    logic          timeout_q, timeout_d;
    logic          irq_en_q, irq_en_d;
    logic [15:0]   cnt_q, cnt_d;
    logic          irq_q, irq_d;

    logic accept, tmo_hit, frame_rise, ctrl_wr, w1c;
    logic unused_bits;

    // hreadyout_q gate keeps a stalled data phase from swallowing a new address phase
    assign accept     = mem_ahb_hready & mem_ahb_htrans[1] & hreadyout_q;
    assign frame_rise = cam_capture_finish & ~fin_q;
    assign ctrl_wr    = wr_pend_q & (wr_addr_q == 12'h004);
    assign w1c        = ctrl_wr & mem_ahb_hwdata[0];

    always_comb begin
        state_d     = state_q;
        hreadyout_d = hreadyout_q;
        hresp_d     = 1'b0;
        hrdata_d    = hrdata_q;
        buf_req_d   = buf_req_q;
        buf_off_d   = buf_off_q;
        k_d         = k_q;
        idx_d       = idx_q;
        bytes_d     = bytes_q;
        tmo_d       = tmo_q;
        wr_pend_d   = 1'b0;
        wr_addr_d   = wr_addr_q;
        tmo_hit     = 1'b0;
        case (state_q)
            S_FETCH: begin
                if (buf_ready) begin
                    buf_req_d = 1'b0;
                    tmo_d     = '0;
                    case (k_q)
                        2'd0:    bytes_d[7:0]   = buf_data;
                        2'd1:    bytes_d[15:8]  = buf_data;
                        2'd2:    bytes_d[23:16] = buf_data;
                        default: ;
                    endcase
                    if (k_q == 2'd3) begin
                        state_d     = S_DONE;
                        hreadyout_d = 1'b1;
                        hrdata_d    = {buf_data, bytes_q};
                    end else begin
                        state_d = S_GAP;
                        k_d     = k_q + 2'd1;
                    end
                end else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    buf_req_d = 1'b0;
                    tmo_hit   = 1'b1;
                    hresp_d   = 1'b1;
                    state_d   = S_ERR1;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            S_GAP: begin
                buf_req_d = 1'b1;
                buf_off_d = {1'b0, idx_q, k_q};
                tmo_d     = '0;
                state_d   = S_FETCH;
            end
            S_ERR1: begin
                hresp_d     = 1'b1;
                hreadyout_d = 1'b1;
                state_d     = S_ERR2;
            end
            default: begin
                // IDLE, DONE and ERR2 all present hreadyout=1 and may take a new address phase
                state_d     = S_IDLE;
                hreadyout_d = 1'b1;
                if (accept) begin
                    if (mem_ahb_haddr[11:9] == WIN_BASE[11:9]) begin
                        hreadyout_d = 1'b0;
                        if (mem_ahb_hwrite) begin
                            hresp_d = 1'b1;
                            state_d = S_ERR1;
                        end else begin
                            state_d   = S_FETCH;
                            buf_req_d = 1'b1;
                            k_d       = 2'd0;
                            idx_d     = mem_ahb_haddr[8:2];
                            buf_off_d = {1'b0, mem_ahb_haddr[8:2], 2'b00};
                            tmo_d     = '0;
                        end
                    end else if (mem_ahb_hwrite) begin
                        wr_pend_d = 1'b1;
                        wr_addr_d = mem_ahb_haddr[11:0];
                    end else begin
                        case (mem_ahb_haddr[11:0])
                            12'h000: hrdata_d = {28'b0, timeout_q, overflow_q, frame_ready_q, cam_capture};
                            12'h004: hrdata_d = {30'b0, irq_en_q, 1'b0};
                            12'h008: hrdata_d = {16'b0, cnt_q};
                            default: hrdata_d = '0;
                        endcase
                    end
                end
            end
        endcase
    end

    // A new frame edge outranks a same-cycle clear; overflow then keeps its value
    always_comb begin
        fin_d         = cam_capture_finish;
        irq_en_d      = ctrl_wr ? mem_ahb_hwdata[1] : irq_en_q;
        frame_ready_d = frame_rise ? 1'b1 : (w1c ? 1'b0 : frame_ready_q);
        overflow_d    = overflow_q;
        if (frame_rise && w1c) begin
            overflow_d = overflow_q;
        end else if (frame_rise && frame_ready_q) begin
            overflow_d = 1'b1;
        end else if (w1c) begin
            overflow_d = 1'b0;
        end
        timeout_d = tmo_hit ? 1'b1 : (w1c ? 1'b0 : timeout_q);
        cnt_d     = cnt_q + 16'(frame_rise);
        irq_d     = frame_ready_q & irq_en_q;
    end

    always_ff @(posedge sys_clock or negedge resetn) begin
        if (!resetn) begin
            state_q       <= S_IDLE;
            hreadyout_q   <= 1'b1;
            hresp_q       <= 1'b0;
            hrdata_q      <= '0;
            buf_req_q     <= 1'b0;
            buf_off_q     <= '0;
            k_q           <= '0;
            idx_q         <= '0;
            bytes_q       <= '0;
            tmo_q         <= '0;
            wr_pend_q     <= 1'b0;
            wr_addr_q     <= '0;
            fin_q         <= 1'b0;
            frame_ready_q <= 1'b0;
            overflow_q    <= 1'b0;
            timeout_q     <= 1'b0;
            irq_en_q      <= 1'b0;
            cnt_q         <= '0;
            irq_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            hreadyout_q   <= hreadyout_d;
            hresp_q       <= hresp_d;
            hrdata_q      <= hrdata_d;
            buf_req_q     <= buf_req_d;
            buf_off_q     <= buf_off_d;
            k_q           <= k_d;
            idx_q         <= idx_d;
            bytes_q       <= bytes_d;
            tmo_q         <= tmo_d;
            wr_pend_q     <= wr_pend_d;
            wr_addr_q     <= wr_addr_d;
            fin_q         <= fin_d;
            frame_ready_q <= frame_ready_d;
            overflow_q    <= overflow_d;
            timeout_q     <= timeout_d;
            irq_en_q      <= irq_en_d;
            cnt_q         <= cnt_d;
            irq_q         <= irq_d;
        end
    end

`ifdef AHB_DMA_REQ_EN
    logic fr_set_q, fr_set_d;
    logic dma_sreq_q, dma_sreq_d;

    always_comb begin
        fr_set_d   = frame_rise;
        dma_sreq_d = fr_set_q ? 1'b1 : (dma_clr ? 1'b0 : dma_sreq_q);
    end

    always_ff @(posedge sys_clock or negedge resetn) begin
        if (!resetn) begin
            fr_set_q   <= 1'b0;
            dma_sreq_q <= 1'b0;
        end else begin
            fr_set_q   <= fr_set_d;
            dma_sreq_q <= dma_sreq_d;
        end
    end

    assign dma_sreq = dma_sreq_q;
`else
    logic unused_dma;
    assign unused_dma = dma_clr;
    assign dma_sreq   = 1'b0;
`endif

    assign unused_bits = ^{mem_ahb_haddr[31:12], mem_ahb_haddr[1:0], mem_ahb_hsize,
                           mem_ahb_htrans[0], mem_ahb_hwdata[31:2]};

    assign mem_ahb_hreadyout = hreadyout_q;
    assign mem_ahb_hresp     = hresp_q;
    assign mem_ahb_hrdata    = hrdata_q;
    assign buf_req           = buf_req_q;
    assign buf_offset        = buf_off_q;
    assign irq               = irq_q;

endmodule
